// File: rtl/video_overlay_box.sv
// Pixel-domain overlay stage: registers the VGA stream by one cycle, paints a fixed-colour
// (optionally blinking) rectangular border, and flags line/frame geometry errors.
module video_overlay_box #(
  parameter int          HDISP        = 800,
  parameter int          VDISP        = 480,
  parameter int          BOX_X        = 100,
  parameter int          BOX_Y        = 60,
  parameter int          BOX_W        = 200,
  parameter int          BOX_H        = 120,
  parameter int          BORDER       = 4,
  parameter logic [23:0] COLOR        = 24'hFF0000,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic        pixel_clk,
  input  logic        pixel_rst,
  input  logic        in_hs,
  input  logic        in_vs,
  input  logic        in_blank,
  input  logic [23:0] in_rgb,
  input  logic        enable,
  input  logic        clr_err,
  output logic        out_hs,
  output logic        out_vs,
  output logic        out_blank,
  output logic [23:0] out_rgb,
  output logic        geom_err
);

  localparam int XW  = $clog2(HDISP + 1);
  localparam int YW  = $clog2(VDISP + 1);
  localparam int FCW = (BLINK_FRAMES == 0) ? 1 : $clog2(2 * BLINK_FRAMES + 1);

  localparam logic [XW-1:0]  X_MAX   = XW'(HDISP);
  localparam logic [YW-1:0]  Y_MAX   = YW'(VDISP);
  localparam logic [FCW-1:0] FC_LAST = FCW'(2 * BLINK_FRAMES - 1);
  localparam logic [FCW-1:0] FC_HALF = FCW'(BLINK_FRAMES);

  // Box edges as 32-bit unsigned so they compare cleanly with zero-extended counters.
  localparam logic [31:0] HD  = 32'(HDISP);
  localparam logic [31:0] VD  = 32'(VDISP);
  localparam logic [31:0] OX0 = 32'(BOX_X);
  localparam logic [31:0] OX1 = 32'(BOX_X + BOX_W);
  localparam logic [31:0] OY0 = 32'(BOX_Y);
  localparam logic [31:0] OY1 = 32'(BOX_Y + BOX_H);
  localparam logic [31:0] IX0 = 32'(BOX_X + BORDER);
  localparam logic [31:0] IX1 = 32'(BOX_X + BOX_W - BORDER);
  localparam logic [31:0] IY0 = 32'(BOX_Y + BORDER);
  localparam logic [31:0] IY1 = 32'(BOX_Y + BOX_H - BORDER);

  logic           hs_q, vs_q, blank_q, err_q, synced_q, show_q;
  logic           err_d, synced_d, show_d;
  logic [23:0]    rgb_q, rgb_d;
  logic [XW-1:0]  x_q, x_d;
  logic [YW-1:0]  y_q, y_d;
  logic [FCW-1:0] fc_q, fc_d;

  logic        blank_fall, vs_fall, in_outer, in_inner, on_screen, border;
  logic [31:0] xe, ye;

  always_comb begin
    blank_fall = blank_q & ~in_blank;
    vs_fall    = vs_q & ~in_vs;
    xe         = 32'(x_q);
    ye         = 32'(y_q);

    x_d = x_q;
    if (blank_fall)                    x_d = '0;
    else if (in_blank && x_q != X_MAX) x_d = x_q + XW'(1);

    y_d = y_q;
    if (vs_fall)                         y_d = '0;
    else if (blank_fall && y_q != Y_MAX) y_d = y_q + YW'(1);

    synced_d = synced_q | vs_fall;
    show_d   = show_q;
    fc_d     = fc_q;
    if (vs_fall) begin
      if (!enable) begin
        fc_d   = '0;
        show_d = 1'b0;
      end else if (BLINK_FRAMES == 0) begin
        show_d = 1'b1;
      end else begin
        show_d = (fc_q < FC_HALF);
        fc_d   = (fc_q == FC_LAST) ? '0 : fc_q + FCW'(1);
      end
    end

    // Set wins over clear when both land in the same cycle.
    err_d = err_q;
    if (clr_err) err_d = 1'b0;
    if (synced_q && ((blank_fall && x_q != X_MAX) || (vs_fall && y_q != Y_MAX))) err_d = 1'b1;

    in_outer  = !(xe < OX0) && (xe < OX1) && !(ye < OY0) && (ye < OY1);
    in_inner  = !(xe < IX0) && (xe < IX1) && !(ye < IY0) && (ye < IY1);
    on_screen = (xe < HD) && (ye < VD);
    border    = in_blank && show_q && on_screen && in_outer && !in_inner;
    rgb_d     = border ? COLOR : in_rgb;
  end

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      blank_q  <= 1'b0;
      rgb_q    <= '0;
      err_q    <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      synced_q <= 1'b0;
      show_q   <= 1'b0;
      fc_q     <= '0;
    end else begin
      hs_q     <= in_hs;
      vs_q     <= in_vs;
      blank_q  <= in_blank;
      rgb_q    <= rgb_d;
      err_q    <= err_d;
      x_q      <= x_d;
      y_q      <= y_d;
      synced_q <= synced_d;
      show_q   <= show_d;
      fc_q     <= fc_d;
    end
  end

  assign out_hs    = hs_q;
  assign out_vs    = vs_q;
  assign out_blank = blank_q;
  assign out_rgb   = rgb_q;
  assign geom_err  = err_q;

endmodule

// File: tb/tb_video_overlay_box.sv
// Directed bench for video_overlay_box on a 16x8 raster: box drawing, pass-through,
// geometry errors, blinking and mid-line reset.
module tb_video_overlay_box;
  localparam int HD = 16;
  localparam int VD = 8;
  localparam logic [23:0] PIX = 24'h123456;
  localparam logic [23:0] RED = 24'hFF0000;

  logic pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  logic        pixel_rst, in_hs, in_vs, in_blank, enable, clr_err;
  logic [23:0] in_rgb;
  logic        o_hs0, o_vs0, o_blank0, o_err0, o_hs1, o_vs1, o_blank1, o_err1;
  logic [23:0] o_rgb0, o_rgb1;

  video_overlay_box #(.HDISP(HD), .VDISP(VD), .BOX_X(4), .BOX_Y(2), .BOX_W(6), .BOX_H(4),
                      .BORDER(1), .COLOR(RED), .BLINK_FRAMES(0)) dut0 (
    .pixel_clk(pixel_clk), .pixel_rst(pixel_rst), .in_hs(in_hs), .in_vs(in_vs),
    .in_blank(in_blank), .in_rgb(in_rgb), .enable(enable), .clr_err(clr_err),
    .out_hs(o_hs0), .out_vs(o_vs0), .out_blank(o_blank0), .out_rgb(o_rgb0), .geom_err(o_err0));

  video_overlay_box #(.HDISP(HD), .VDISP(VD), .BOX_X(4), .BOX_Y(2), .BOX_W(6), .BOX_H(4),
                      .BORDER(1), .COLOR(RED), .BLINK_FRAMES(2)) dut1 (
    .pixel_clk(pixel_clk), .pixel_rst(pixel_rst), .in_hs(in_hs), .in_vs(in_vs),
    .in_blank(in_blank), .in_rgb(in_rgb), .enable(enable), .clr_err(clr_err),
    .out_hs(o_hs1), .out_vs(o_vs1), .out_blank(o_blank1), .out_rgb(o_rgb1), .geom_err(o_err1));

  typedef struct {
    int          x;
    int          y;
    logic [23:0] exp;
  } probe_t;

  typedef struct {
    logic        hs;
    logic        vs;
    logic        blank;
    logic [23:0] rgb;
  } pass_t;

  int          errors = 0;
  int          checks = 0;
  logic [23:0] cap [VD][HD];
  logic        err_at_vs, err_at_fall, err_before;

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit on_border(int x, int y);
    bit outer, inner;
    outer = (x >= 4) && (x < 10) && (y >= 2) && (y < 6);
    inner = (x >= 5) && (x < 9) && (y >= 3) && (y < 5);
    return outer && !inner;
  endfunction

  // exp_box: -1 = don't check pixels, 0 = no box expected, 1 = box expected (on dut 'sel').
  task automatic send_lines(input int n, input int short_line, input int short_len,
                            input int exp_box, input int sel, input int drop_en_line);
    int          len;
    logic [23:0] act, exp;
    for (int l = 0; l < n; l++) begin
      if (l == drop_en_line) enable = 1'b0;
      len = (l == short_line) ? short_len : HD;
      for (int p = 0; p < len; p++) begin
        in_hs = 1'b1; in_blank = 1'b1; in_rgb = PIX;
        tick();
        act = (sel == 1) ? o_rgb1 : o_rgb0;
        if (l < VD) cap[l][p] = o_rgb0;
        if (exp_box >= 0) begin
          exp = (exp_box == 1 && on_border(p, l)) ? RED : PIX;
          chk($sformatf("pix_d%0d(%0d,%0d)", sel, p, l), 32'(act), 32'(exp));
        end
        if (l == short_line) err_before = o_err0;
      end
      for (int b = 0; b < 4; b++) begin
        in_blank = 1'b0; in_hs = !(b == 1 || b == 2); in_rgb = 24'h0;
        tick();
        if (b == 0 && l == short_line) err_at_fall = o_err0;
      end
    end
  endtask

  task automatic send_frame(input int n, input int short_line, input int short_len,
                            input int exp_box, input int sel, input int drop_en_line);
    in_vs = 1'b0; in_blank = 1'b0; in_hs = 1'b1;
    tick();
    err_at_vs = o_err0;
    tick();
    in_vs = 1'b1;
    tick();
    tick();
    send_lines(n, short_line, short_len, exp_box, sel, drop_en_line);
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    probe_t probes [15];
    pass_t  pv [8];
    int     exp_blink [6];

    probes[0]  = '{4, 2, RED};  probes[1]  = '{9, 2, RED};  probes[2]  = '{6, 2, RED};
    probes[3]  = '{4, 5, RED};  probes[4]  = '{9, 5, RED};  probes[5]  = '{4, 3, RED};
    probes[6]  = '{9, 4, RED};  probes[7]  = '{5, 3, PIX};  probes[8]  = '{8, 4, PIX};
    probes[9]  = '{3, 2, PIX};  probes[10] = '{10, 2, PIX}; probes[11] = '{4, 1, PIX};
    probes[12] = '{4, 6, PIX};  probes[13] = '{0, 0, PIX};  probes[14] = '{15, 7, PIX};

    pv[0] = '{1'b1, 1'b0, 1'b0, 24'h000000}; pv[1] = '{1'b0, 1'b0, 1'b0, 24'hABCDEF};
    pv[2] = '{1'b1, 1'b1, 1'b1, 24'h123456}; pv[3] = '{1'b1, 1'b1, 1'b1, 24'hFFFFFF};
    pv[4] = '{1'b0, 1'b1, 1'b0, 24'h0F0F0F}; pv[5] = '{1'b1, 1'b1, 1'b1, 24'hA5A5A5};
    pv[6] = '{1'b1, 1'b0, 1'b1, 24'h5A5A5A}; pv[7] = '{1'b0, 1'b1, 1'b1, 24'h000001};

    exp_blink = '{1, 1, 0, 0, 1, 0};

    // Reset values
    in_hs = 1'b1; in_vs = 1'b1; in_blank = 1'b0; in_rgb = 24'h0;
    enable = 1'b1; clr_err = 1'b0; pixel_rst = 1'b1;
    tick(); tick();
    chk("rst_hs", 32'(o_hs0), 32'd1);
    chk("rst_vs", 32'(o_vs0), 32'd1);
    chk("rst_blank", 32'(o_blank0), 32'd0);
    chk("rst_rgb", 32'(o_rgb0), 32'd0);
    chk("rst_err", 32'(o_err0), 32'd0);
    chk("rst_err1", 32'(o_err1), 32'd0);
    pixel_rst = 1'b0;

    // Partial frame before first frame start is not checked, then three clean frames
    send_lines(3, -1, 0, -1, 0, -1);
    chk("partial_no_err", 32'(o_err0), 32'd0);
    for (int f = 0; f < 3; f++) send_frame(VD, -1, 0, 1, 0, -1);
    chk("clean_no_err", 32'(o_err0), 32'd0);
    foreach (probes[i])
      chk($sformatf("probe(%0d,%0d)", probes[i].x, probes[i].y),
          32'(cap[probes[i].y][probes[i].x]), 32'(probes[i].exp));

    // Short line: error one cycle after its blank fall, sticky, cleared by clr_err
    send_frame(VD, 3, 15, -1, 0, -1);
    chk("short_line_before", 32'(err_before), 32'd0);
    chk("short_line_at_fall", 32'(err_at_fall), 32'd1);
    send_frame(VD, -1, 0, -1, 0, -1);
    chk("err_sticky", 32'(o_err0), 32'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("err_cleared", 32'(o_err0), 32'd0);

    // Seven-line frame: error appears at the next frame start
    send_frame(VD - 1, -1, 0, -1, 0, -1);
    chk("short_frame_before_vs", 32'(o_err0), 32'd0);
    send_frame(VD, -1, 0, -1, 0, -1);
    chk("short_frame_at_vs", 32'(err_at_vs), 32'd1);

    // Asynchronous reset mid-line
    in_vs = 1'b0; tick(); in_vs = 1'b1; tick();
    for (int p = 0; p < 3; p++) begin
      in_blank = 1'b1; in_rgb = PIX; in_hs = 1'b0;
      tick();
    end
    chk("pre_rst_err", 32'(o_err0), 32'd1);
    #2 pixel_rst = 1'b1;
    #1;
    chk("midrst_hs", 32'(o_hs0), 32'd1);
    chk("midrst_vs", 32'(o_vs0), 32'd1);
    chk("midrst_blank", 32'(o_blank0), 32'd0);
    chk("midrst_rgb", 32'(o_rgb0), 32'd0);
    chk("midrst_err", 32'(o_err0), 32'd0);
    tick();
    pixel_rst = 1'b0; in_blank = 1'b0; in_hs = 1'b1;
    tick();
    send_lines(2, 0, 5, -1, 0, -1);
    chk("post_rst_partial_no_err", 32'(o_err0), 32'd0);
    send_frame(VD, -1, 0, 1, 0, -1);
    send_frame(VD, -1, 0, 1, 0, -1);
    chk("post_rst_no_err", 32'(o_err0), 32'd0);

    // Blinking (BLINK_FRAMES=2), enable dropped mid-frame 5
    pixel_rst = 1'b1; enable = 1'b1;
    tick();
    pixel_rst = 1'b0;
    send_lines(1, -1, 0, -1, 1, -1);
    for (int f = 0; f < 6; f++) send_frame(VD, -1, 0, exp_blink[f], 1, (f == 4) ? 3 : -1);
    chk("blink_no_err", 32'(o_err1), 32'd0);

    // Pass-through with the overlay disabled
    foreach (pv[i]) begin
      in_hs = pv[i].hs; in_vs = pv[i].vs; in_blank = pv[i].blank; in_rgb = pv[i].rgb;
      tick();
      chk($sformatf("pass%0d_hs", i), 32'(o_hs0), 32'(pv[i].hs));
      chk($sformatf("pass%0d_vs", i), 32'(o_vs0), 32'(pv[i].vs));
      chk($sformatf("pass%0d_blank", i), 32'(o_blank0), 32'(pv[i].blank));
      chk($sformatf("pass%0d_rgb", i), 32'(o_rgb0), 32'(pv[i].rgb));
      chk($sformatf("pass%0d_d1", i), {5'd0, o_hs1, o_vs1, o_blank1, o_rgb1},
          {5'd0, pv[i].hs, pv[i].vs, pv[i].blank, pv[i].rgb});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
